muller_c_elem_formal: RTL and testbench

//   Synchronous model of a 3-lane two-input Muller C-element bank, plus a
//   6-input C-element. Used in the async project's formal/cover harness:

---
 rtl/muller_c_elem_formal.sv | 128 ++++++++++++
 tb/tb_muller_c_elem_formal.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muller_c_elem_formal.sv
// Synchronous model of a 3-lane two-input Muller C-element bank plus a
// 6-input C-element over every io_in bit. io_in is synchronised first.
// Alongside the C-element state the block keeps a saturating transition
// counter, a sticky shadow-check flag, and sticky cover events.
module muller_c_elem_formal #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       io_in,
  output logic [2:0]       c_out,
  output logic             c_all,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             prop_fail,
  output logic             cover_full,
  output logic             cover_all
);

  typedef enum logic [1:0] {
    COV_IDLE = 2'd0,
    COV_HIGH = 2'd1,
    COV_DONE = 2'd2
  } cov_state_e;

  logic [5:0]       sync_q [SYNC_STAGES];
  logic [5:0]       s;
  logic [2:0]       a, b;

  logic [2:0]       c_out_q, c_out_d;
  logic             c_all_q, c_all_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cover_all_q, cover_all_d;
  cov_state_e       cov_q, cov_d;

  // Shadow-check state: inputs and lane state from the previous cycle.
  logic             chk_vld_q;
  logic [5:0]       prev_s_q;
  logic [2:0]       prev_c_q;
  logic             prop_fail_q, prop_fail_d;
  logic [2:0]       prev_agree, lane_bad;

  assign s = sync_q[SYNC_STAGES-1];
  assign a = s[2:0];
  assign b = s[5:3];

  // Input synchroniser chain; io_in reaches s after SYNC_STAGES edges.
  // NOTE: the synchroniser is a small flop array, not a RAM, so it is reset
  // like any other register; a RAM would be left unreset and cleared by logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Next-state: C-element rule per lane and over all six bits, the
  // saturating change counter, sticky cover_all and the lane-0 cover FSM.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    // Set when both inputs are 1, keep while at least one input is still 1;
    // this is exactly "agree -> follow, disagree -> hold".
    c_out_d     = (a & b) | (c_out_q & (a | b));
    c_all_d     = (&s) | (c_all_q & (|s));
    cnt_d       = cnt_q;
    cover_all_d = cover_all_q | c_all_d;
    cov_d       = cov_q;

    if ((c_out_d != c_out_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (cov_q)
      COV_IDLE: if (!c_out_q[0] && c_out_d[0]) cov_d = COV_HIGH;
      COV_HIGH: if (c_out_q[0] && !c_out_d[0]) cov_d = COV_DONE;
      COV_DONE: cov_d = COV_DONE;
      default:  cov_d = COV_IDLE;
    endcase
  end

  // Shadow invariant check on the registered lane state: a lane may only
  // have changed if its previous inputs agreed, and when they agreed the
  // lane must now equal that agreed value.
  always_comb begin
    prev_agree  = ~(prev_s_q[2:0] ^ prev_s_q[5:3]);
    lane_bad    = ((c_out_q ^ prev_c_q) & ~prev_agree)
                | (prev_agree & (c_out_q ^ prev_s_q[2:0]));
    prop_fail_d = prop_fail_q | (chk_vld_q & (|lane_bad));
  end

  // State registers; reset clears everything including the sticky flags.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_out_q     <= '0;
      c_all_q     <= 1'b0;
      cnt_q       <= '0;
      cover_all_q <= 1'b0;
      cov_q       <= COV_IDLE;
      chk_vld_q   <= 1'b0;
      prev_s_q    <= '0;
      prev_c_q    <= '0;
      prop_fail_q <= 1'b0;
    end else begin
      c_out_q     <= c_out_d;
      c_all_q     <= c_all_d;
      cnt_q       <= cnt_d;
      cover_all_q <= cover_all_d;
      cov_q       <= cov_d;
      chk_vld_q   <= 1'b1;
      prev_s_q    <= s;
      prev_c_q    <= c_out_q;
      prop_fail_q <= prop_fail_d;
    end
  end

  assign c_out      = c_out_q;
  assign c_all      = c_all_q;
  assign toggle_cnt = cnt_q;
  assign prop_fail  = prop_fail_q;
  assign cover_full = (cov_q == COV_DONE);
  assign cover_all  = cover_all_q;

endmodule

// File: tb/tb_muller_c_elem_formal.sv
// Self-checking bench for muller_c_elem_formal: a vector table, hand-written
// corner sequences (latency, lane-0 cover, saturation, async reset) and a
// random run against a behavioural C-element model.
module tb_muller_c_elem_formal;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [5:0]       io_in;
  logic [2:0]       c_out;
  logic             c_all;
  logic [CNT_W-1:0] toggle_cnt;
  logic             prop_fail;
  logic             cover_full;
  logic             cover_all;

  int errors = 0;
  int checks = 0;

  muller_c_elem_formal #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_in      (io_in),
    .c_out      (c_out),
    .c_all      (c_all),
    .toggle_cnt (toggle_cnt),
    .prop_fail  (prop_fail),
    .cover_full (cover_full),
    .cover_all  (cover_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [5:0] m_pipe[$];
  logic [2:0] m_c;
  logic       m_call;
  int         m_cnt;
  logic       m_seen_one;
  logic       m_cf;
  logic       m_ca;

  task automatic model_reset();
    m_pipe.delete();
    for (int k = 0; k < SYNC_STAGES; k++) m_pipe.push_back(6'h00);
    m_c = 3'b000; m_call = 1'b0; m_cnt = 0;
    m_seen_one = 1'b0; m_cf = 1'b0; m_ca = 1'b0;
  endtask

  // One rising edge: the inputs seen by the C-elements are the io_in value
  // sampled SYNC_STAGES edges ago.
  task automatic model_edge(input logic [5:0] io_at_edge);
    logic [5:0] sv;
    logic [2:0] nc;
    sv = m_pipe.pop_front();
    m_pipe.push_back(io_at_edge);
    for (int i = 0; i < 3; i++) begin
      if (sv[i] == sv[i+3]) nc[i] = sv[i];
      else                  nc[i] = m_c[i];
    end
    if (sv == 6'h3F)      m_call = 1'b1;
    else if (sv == 6'h00) m_call = 1'b0;
    if (nc != m_c && m_cnt < CNT_MAX) m_cnt++;
    if (m_seen_one && !nc[0]) m_cf = 1'b1;
    if (nc[0]) m_seen_one = 1'b1;
    if (m_call) m_ca = 1'b1;
    m_c = nc;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic [5:0] io_e;
    logic       rst_e;
    io_e  = io_in;
    rst_e = rst_n;
    @(posedge clk);
    #1;
    if (rst_e) model_edge(io_e);
  endtask

  task automatic do_reset(input logic [5:0] io_val);
    rst_n = 1'b0;
    io_in = io_val;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".c_out"},      32'(c_out),      32'(m_c));
    check({tag, ".c_all"},      32'(c_all),      32'(m_call));
    check({tag, ".toggle_cnt"}, 32'(toggle_cnt), 32'(m_cnt));
    check({tag, ".cover_full"}, 32'(cover_full), 32'(m_cf));
    check({tag, ".cover_all"},  32'(cover_all),  32'(m_ca));
    check({tag, ".prop_fail"},  32'(prop_fail),  32'd0);
  endtask

  typedef struct {
    logic [5:0] io;
    logic [2:0] c;
    logic       call;
    int         cnt;
    logic       cf;
    logic       ca;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {io_in, c_out, c_all, toggle_cnt, cover_full, cover_all} after the
    // vector has been held SYNC_STAGES+1 edges; applied in order.
    vt[0] = '{6'b000110, 3'b000, 1'b0, 0, 1'b0, 1'b0};
    vt[1] = '{6'b111111, 3'b111, 1'b1, 1, 1'b0, 1'b1};
    vt[2] = '{6'b000110, 3'b110, 1'b1, 2, 1'b1, 1'b1};
    vt[3] = '{6'b000000, 3'b000, 1'b0, 3, 1'b1, 1'b1};
    vt[4] = '{6'b111000, 3'b000, 1'b0, 3, 1'b1, 1'b1};
    vt[5] = '{6'b000111, 3'b000, 1'b0, 3, 1'b1, 1'b1};
    vt[6] = '{6'b111111, 3'b111, 1'b1, 4, 1'b1, 1'b1};
    vt[7] = '{6'b011110, 3'b111, 1'b1, 4, 1'b1, 1'b1};

    rst_n = 1'b0;
    io_in = 6'h00;
    #2;
    check("reset.c_out", 32'(c_out), 32'd0);
    check("reset.toggle_cnt", 32'(toggle_cnt), 32'd0);

    // Lane 0 agrees at 0, lanes 1 and 2 disagree: everything holds at 0.
    do_reset(6'b000110);
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold0.c_out", 32'(c_out), 32'd0);
      check("hold0.c_all", 32'(c_all), 32'd0);
      check("hold0.toggle_cnt", 32'(toggle_cnt), 32'd0);
      check("hold0.prop_fail", 32'(prop_fail), 32'd0);
    end

    // Vector table, starting from a fresh reset.
    do_reset(6'b000000);
    for (int i = 0; i < 8; i++) begin
      io_in = vt[i].io;
      repeat (SYNC_STAGES + 1) step();
      check($sformatf("vec%0d.c_out", i),      32'(c_out),      32'(vt[i].c));
      check($sformatf("vec%0d.c_all", i),      32'(c_all),      32'(vt[i].call));
      check($sformatf("vec%0d.toggle_cnt", i), 32'(toggle_cnt), 32'(vt[i].cnt));
      check($sformatf("vec%0d.cover_full", i), 32'(cover_full), 32'(vt[i].cf));
      check($sformatf("vec%0d.cover_all", i),  32'(cover_all),  32'(vt[i].ca));
      check($sformatf("vec%0d.prop_fail", i),  32'(prop_fail),  32'd0);
    end

    // Latency: io_in change appears on c_out on exactly the SYNC_STAGES+1 edge.
    do_reset(6'b000000);
    io_in = 6'b111111;
    repeat (SYNC_STAGES) step();
    check("latency.early", 32'(c_out), 32'd0);
    step();
    check("latency.c_out", 32'(c_out), 32'h7);
    check("latency.c_all", 32'(c_all), 32'd1);

    // Lane-0 cover sequence.
    do_reset(6'b000000);
    io_in = 6'b000001;                       // A0=1, B0=0
    repeat (SYNC_STAGES + 1) step();
    check("lane0.disagree", 32'(c_out), 32'd0);
    io_in = 6'b001001;                       // B0=1
    repeat (SYNC_STAGES + 1) step();
    check("lane0.rise", 32'(c_out), 32'd1);
    check("lane0.cf_after_rise", 32'(cover_full), 32'd0);
    io_in = 6'b001000;                       // A0=0
    repeat (SYNC_STAGES + 1) step();
    check("lane0.hold1", 32'(c_out), 32'd1);
    io_in = 6'b000000;                       // B0=0
    repeat (SYNC_STAGES + 1) step();
    check("lane0.fall", 32'(c_out), 32'd0);
    check("lane0.cover_full", 32'(cover_full), 32'd1);
    check("lane0.cover_all", 32'(cover_all), 32'd0);

    // Saturation: toggle lane 0 every cycle for 300 cycles.
    do_reset(6'b000000);
    for (int k = 0; k < 300; k++) begin
      io_in = (k % 2 == 0) ? 6'b001001 : 6'b000000;
      step();
      if (k == 100) check_model("sat.mid");
    end
    check("sat.toggle_cnt", 32'(toggle_cnt), 32'(CNT_MAX));
    repeat (4) step();
    check("sat.still", 32'(toggle_cnt), 32'(CNT_MAX));

    // Asynchronous reset between edges while c_out=111.
    do_reset(6'b000000);
    io_in = 6'b111111;
    repeat (SYNC_STAGES + 1) step();
    check("areset.pre", 32'(c_out), 32'h7);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset.c_out",      32'(c_out),      32'd0);
    check("areset.c_all",      32'(c_all),      32'd0);
    check("areset.toggle_cnt", 32'(toggle_cnt), 32'd0);
    check("areset.cover_all",  32'(cover_all),  32'd0);
    check("areset.cover_full", 32'(cover_full), 32'd0);
    check("areset.prop_fail",  32'(prop_fail),  32'd0);
    model_reset();
    io_in = 6'h00;
    step();
    rst_n = 1'b1;

    // Random run against the model.
    for (int k = 0; k < 10000; k++) begin
      io_in = 6'($urandom);
      step();
      check("rand.c_out", 32'(c_out), 32'(m_c));
      check("rand.c_all", 32'(c_all), 32'(m_call));
      if (k % 50 == 0) check_model("rand");
    end
    check("rand.prop_fail", 32'(prop_fail), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
